// File: rtl/resize_pkg.sv
// Shared types and default sizing for the resize accumulator slice.
package resize_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int IN_W_DEF  = 5;
  localparam int ACC_W_DEF = 6;
  localparam int BURST_DEF = 4;

endpackage

// File: rtl/resize_accum_if.sv
// Sample-in / sum-out handshake bundle for resize_accum.
interface resize_accum_if #(
  parameter int IN_W  = resize_pkg::IN_W_DEF,
  parameter int ACC_W = resize_pkg::ACC_W_DEF
);
  logic             in_valid;
  logic [IN_W-1:0]  in_data;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_wrap;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, out_wrap
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, out_wrap
  );
endinterface

// File: rtl/sat_free_adder.sv
// Accumulator adder: unsigned sample zero-extended, sum truncated, carry-out exposed.
module sat_free_adder #(
  parameter int IN_W  = 5,
  parameter int ACC_W = 6
) (
  input  logic [ACC_W-1:0] a,
  input  logic [IN_W-1:0]  b,
  output logic [ACC_W-1:0] sum,
  output logic             carry
);
  logic [ACC_W:0] full;

  assign full         = {1'b0, a} + (ACC_W+1)'(b);
  assign {carry, sum} = full;
endmodule

// File: rtl/resize_accum.sv
// Sums BURST unsigned samples into one ACC_W-bit result with a sticky wrap flag.
//   state | meaning
//   IDLE  | no samples held, ready for the first sample of a burst
//   ACCUM | 1..BURST-1 samples held
//   HOLD  | burst sum presented until downstream accepts
module resize_accum
  import resize_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int BURST = BURST_DEF
) (
  input logic           clk,
  input logic           rst_n,
  resize_accum_if.slave bus
);
  localparam int CNT_W = $clog2(BURST + 1);

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] add_sum;
  logic             add_carry;
  logic             wrap;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             in_ready;
  logic             out_valid;
  logic             in_xfer;
  logic             out_xfer;
  logic             last_smp;

  sat_free_adder #(.IN_W(IN_W), .ACC_W(ACC_W)) u_adder (
    .a     (acc),
    .b     (bus.in_data),
    .sum   (add_sum),
    .carry (add_carry)
  );

  assign in_xfer  = bus.in_valid & in_ready;
  assign out_xfer = out_valid & bus.out_ready;
  assign cnt_inc  = cnt + CNT_W'(1);
  assign last_smp = (cnt_inc == CNT_W'(BURST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_xfer)             state_nxt = ACCUM;
      ACCUM:   if (in_xfer && last_smp) state_nxt = HOLD;
      HOLD:    if (out_xfer)            state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state != HOLD);
    out_valid = (state == HOLD);
  end

  // acc/wrap are the output registers; HOLD leaves them untouched so the result stays stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      wrap <= 1'b0;
      cnt  <= '0;
    end else begin
      case (state)
        IDLE: if (in_xfer) begin
          acc  <= ACC_W'(bus.in_data);
          wrap <= 1'b0;
          cnt  <= CNT_W'(1);
        end
        ACCUM: if (in_xfer) begin
          acc  <= add_sum;
          wrap <= wrap | add_carry;
          cnt  <= cnt_inc;
        end
        HOLD: if (out_xfer) cnt <= '0;
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_sum   = acc;
  assign bus.out_wrap  = wrap;
endmodule

// File: tb/tb_resize_accum.sv
// Directed bench for resize_accum: table of 4-sample bursts plus stall and reset sequences.
module tb_resize_accum;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  resize_accum_if #(.IN_W(5), .ACC_W(6)) bus ();

  resize_accum #(.IN_W(5), .ACC_W(6), .BURST(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][4:0] smp;
    int              gap;
    logic [5:0]      sum;
    logic            wrap;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mk(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                              input logic [4:0] d, input int gap, input logic [5:0] sum,
                              input logic wrap);
    vec_t v;
    v.smp[0] = a;
    v.smp[1] = b;
    v.smp[2] = c;
    v.smp[3] = d;
    v.gap    = gap;
    v.sum    = sum;
    v.wrap   = wrap;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drives four samples; gap idle cycles are inserted between the 2nd and 3rd sample.
  task automatic send_burst(input logic [3:0][4:0] smp, input int gap, input string tag);
    for (int i = 0; i < 4; i++) begin
      if (i == 2 && gap > 0) begin
        bus.in_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
          tick();
          check({tag, " gap in_ready"}, 32'(bus.in_ready), 32'd1);
          check({tag, " gap out_valid"}, 32'(bus.out_valid), 32'd0);
        end
      end
      bus.in_valid = 1'b1;
      bus.in_data  = smp[i];
      check({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
      if (i == 3) check({tag, " early out_valid"}, 32'(bus.out_valid), 32'd0);
      tick();
    end
    bus.in_valid = 1'b0;
    check({tag, " latency out_valid"}, 32'(bus.out_valid), 32'd1);
  endtask

  task automatic check_result(input logic [5:0] sum, input logic wrap, input string tag);
    check({tag, " out_sum"}, 32'(bus.out_sum), 32'(sum));
    check({tag, " out_wrap"}, 32'(bus.out_wrap), 32'(wrap));
  endtask

  task automatic accept(input string tag);
    bus.out_ready = 1'b1;
    tick();
    check({tag, " post-accept out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, " post-accept in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " rst out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, " rst out_sum"}, 32'(bus.out_sum), 32'd0);
    check({tag, " rst out_wrap"}, 32'(bus.out_wrap), 32'd0);
    check({tag, " rst in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    vecs[0] = mk(5'd9,  5'd9,  5'd9,  5'd9,  0, 6'd36, 1'b0);
    vecs[1] = mk(5'd31, 5'd31, 5'd31, 5'd31, 0, 6'd60, 1'b1);
    vecs[2] = mk(5'd1,  5'd2,  5'd3,  5'd4,  3, 6'd10, 1'b0);
    vecs[3] = mk(5'd16, 5'd16, 5'd16, 5'd15, 0, 6'd63, 1'b0);
    vecs[4] = mk(5'd16, 5'd16, 5'd16, 5'd16, 0, 6'd0,  1'b1);
    vecs[5] = mk(5'd0,  5'd0,  5'd0,  5'd0,  0, 6'd0,  1'b0);
    vecs[6] = mk(5'd31, 5'd31, 5'd2,  5'd0,  0, 6'd0,  1'b1);
    vecs[7] = mk(5'd20, 5'd30, 5'd31, 5'd0,  1, 6'd17, 1'b1);

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    check_reset_outputs("init");
    rst_n = 1'b1;
    tick();
    check_reset_outputs("post-init");

    bus.out_ready = 1'b1;
    foreach (vecs[v]) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      send_burst(vecs[v].smp, vecs[v].gap, tag);
      check_result(vecs[v].sum, vecs[v].wrap, tag);
      accept(tag);
    end

    // Downstream stall with upstream still offering samples.
    bus.out_ready = 1'b0;
    send_burst(mk(5'd9, 5'd9, 5'd9, 5'd9, 0, 6'd36, 1'b0).smp, 0, "stall");
    bus.in_valid = 1'b1;
    bus.in_data  = 5'd5;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall in_ready", 32'(bus.in_ready), 32'd0);
      check("stall out_valid", 32'(bus.out_valid), 32'd1);
      check("stall out_sum", 32'(bus.out_sum), 32'd36);
    end
    accept("stall");
    send_burst(mk(5'd5, 5'd5, 5'd5, 5'd5, 0, 6'd20, 1'b0).smp, 0, "release");
    check_result(6'd20, 1'b0, "release");
    accept("release");

    // Asynchronous reset partway through a burst, between clock edges.
    bus.in_valid = 1'b1;
    bus.in_data  = 5'd31;
    tick();
    tick();
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midburst");
    tick();
    rst_n = 1'b1;
    tick();
    send_burst(mk(5'd1, 5'd1, 5'd1, 5'd1, 0, 6'd4, 1'b0).smp, 0, "after-rst");
    check_result(6'd4, 1'b0, "after-rst");

    // Reset while a wrapped result is held.
    bus.out_ready = 1'b0;
    accept("pre-hold");
    bus.out_ready = 1'b0;
    send_burst(mk(5'd31, 5'd31, 5'd31, 5'd31, 0, 6'd60, 1'b1).smp, 0, "hold-rst");
    check_result(6'd60, 1'b1, "hold-rst");
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("hold");
    tick();
    rst_n = 1'b1;
    tick();
    check_reset_outputs("hold-released");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
